// File: rtl/seq_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: ALUop and Func encodings, FSM
// state codes, operation decode and signed-overflow detection.
package seq_alu_pkg;

  localparam logic [1:0] ALUOP_ADD  = 2'd0;
  localparam logic [1:0] ALUOP_SUB  = 2'd1;
  localparam logic [1:0] ALUOP_FUNC = 2'd2;
  localparam logic [1:0] ALUOP_OR   = 2'd3;

  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_AND   = 4'd2,
    FN_OR    = 4'd3,
    FN_NOR   = 4'd4,
    FN_NAND  = 4'd5,
    FN_XOR   = 4'd6,
    FN_SLT   = 4'd7,
    FN_SLL   = 4'd8,
    FN_SRL   = 4'd9,
    FN_SRA   = 4'd10,
    FN_MUL   = 4'd11,
    FN_RSV12 = 4'd12,
    FN_RSV13 = 4'd13,
    FN_RSV14 = 4'd14,
    FN_RSV15 = 4'd15
  } func_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MUL   = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  // Fold ALUop and Func into a single operation code.
  function automatic func_e decode_op(input logic [1:0] aluop, input logic [3:0] func);
    func_e op;
    case (aluop)
      ALUOP_ADD:  op = FN_ADD;
      ALUOP_SUB:  op = FN_SUB;
      ALUOP_FUNC: op = func_e'(func);
      ALUOP_OR:   op = FN_OR;
      default:    op = FN_OR;
    endcase
    return op;
  endfunction

  // Signed overflow from operand and result sign bits. For subtraction the
  // operands must differ in sign for an overflow to be possible.
  function automatic logic signed_ovf(input logic a_s, input logic b_s,
                                      input logic r_s, input logic is_sub);
    logic ovf;
    if (is_sub) ovf = (a_s != b_s) && (r_s != a_s);
    else        ovf = (a_s == b_s) && (r_s != a_s);
    return ovf;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the datapath control and seq_alu.
//   master: drives start, A, B, ALUop, Func; observes status and results
//   slave : the ALU itself
interface seq_alu_if #(parameter int WIDTH = 16);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ALUop;
  logic [3:0]       Func;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             isZero;
  logic             isNegative;
  logic             overflow;

  modport master (
    output start, A, B, ALUop, Func,
    input  busy, done, Result, ResultHi, isZero, isNegative, overflow
  );

  modport slave (
    input  start, A, B, ALUop, Func,
    output busy, done, Result, ResultHi, isZero, isNegative, overflow
  );

endinterface

// File: rtl/seq_alu_comb.sv
// Combinational single-cycle unit: add, sub, and, or, nor, nand, xor, slt.
//   a_i, b_i    operands
//   func_i      decoded operation
//   result_o    low result (0 for any op this unit does not handle)
//   overflow_o  signed overflow for add, sub and slt; 0 otherwise
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  func_e            func_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  // Direct signed compare, so slt stays right even when A-B overflows.
  assign lt_signed = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (func_i)
      FN_ADD: begin
        result_o   = sum;
        overflow_o = signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      FN_SUB: begin
        result_o   = diff;
        overflow_o = signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      FN_AND:  result_o = a_i & b_i;
      FN_OR:   result_o = a_i | b_i;
      FN_NOR:  result_o = ~(a_i | b_i);
      FN_NAND: result_o = ~(a_i & b_i);
      FN_XOR:  result_o = a_i ^ b_i;
      FN_SLT: begin
        result_o   = {{(WIDTH-1){1'b0}}, lt_signed};
        overflow_o = signed_ovf(a_i[WIDTH-1], b_i[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake. Single-cycle ops come from
// seq_alu_comb; shifts iterate one bit per cycle; mul is shift-and-add over a
// 2*WIDTH accumulator. Results and flags are loaded on the edge entering FIN,
// so they are valid in the done cycle and held until the next completion.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      seq_alu_if slave (operands, op select, status, results)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | iterating a shift, one bit per cycle, busy=1
// ST_MUL   | shift-and-add multiply, one multiplier bit per cycle, busy=1
// ST_FIN   | results valid, done=1, busy=0 (new start accepted here)
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic    clk,
  input  logic    reset_n,
  seq_alu_if.slave bus
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = SHW + 1;

  logic [1:0]         state_q, state_d;
  func_e              func_q, func_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  func_e              func_in;
  logic [WIDTH-1:0]   comb_res;
  logic               comb_ovf;
  logic               busy;
  logic               accept;
  logic [WIDTH-1:0]   sh_step;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [CNT_W-1:0]   cnt_dec;

  logic               fin_load;
  logic               fin_valid;
  logic [WIDTH-1:0]   fin_res;
  logic [WIDTH-1:0]   fin_hi;
  logic               fin_ovf;

  assign func_in = decode_op(bus.ALUop, bus.Func);

  seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i        (bus.A),
    .b_i        (bus.B),
    .func_i     (func_in),
    .result_o   (comb_res),
    .overflow_o (comb_ovf)
  );

  assign busy    = (state_q == ST_SHIFT) || (state_q == ST_MUL);
  assign accept  = bus.start && !busy;
  assign cnt_dec = cnt_q - CNT_W'(1);

  always_comb begin
    case (func_q)
      FN_SLL:  sh_step = {sh_q[WIDTH-2:0], 1'b0};
      FN_SRA:  sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_step = {1'b0, sh_q[WIDTH-1:1]};
    endcase
  end

  // Multiplier sits in the low half; each step adds A into the high half
  // when the current multiplier bit is set, then shifts the whole thing right
  // (carry included) so the next multiplier bit lands in bit 0.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    a_d       = a_q;
    sh_d      = sh_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    fin_load  = 1'b0;
    fin_valid = 1'b1;
    fin_res   = '0;
    fin_hi    = '0;
    fin_ovf   = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_dec;
        if (cnt_dec == '0) begin
          state_d  = ST_FIN;
          fin_load = 1'b1;
          fin_res  = sh_step;
        end
      end

      ST_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_dec;
        if (cnt_dec == '0) begin
          state_d  = ST_FIN;
          fin_load = 1'b1;
          fin_res  = prod_step[WIDTH-1:0];
          fin_hi   = prod_step[2*WIDTH-1:WIDTH];
          fin_ovf  = |prod_step[2*WIDTH-1:WIDTH];
        end
      end

      default: begin
        // IDLE and FIN behave alike: both accept a new request.
        state_d = ST_IDLE;
        if (accept) begin
          func_d = func_in;
          a_d    = bus.A;
          case (func_in)
            FN_SLL, FN_SRL, FN_SRA: begin
              if (bus.B[SHW-1:0] == '0) begin
                state_d  = ST_FIN;
                fin_load = 1'b1;
                fin_res  = bus.A;
              end else begin
                state_d = ST_SHIFT;
                sh_d    = bus.A;
                cnt_d   = {1'b0, bus.B[SHW-1:0]};
              end
            end
            FN_MUL: begin
              state_d = ST_MUL;
              prod_d  = {{WIDTH{1'b0}}, bus.B};
              cnt_d   = CNT_W'(WIDTH);
            end
            FN_RSV12, FN_RSV13, FN_RSV14, FN_RSV15: begin
              // Reserved: zero result and every flag forced low, isZero too.
              state_d   = ST_FIN;
              fin_load  = 1'b1;
              fin_valid = 1'b0;
            end
            default: begin
              state_d  = ST_FIN;
              fin_load = 1'b1;
              fin_res  = comb_res;
              fin_ovf  = comb_ovf;
            end
          endcase
        end
      end
    endcase

    if (fin_load) begin
      res_d  = fin_res;
      hi_d   = fin_hi;
      zero_d = fin_valid && (fin_res == '0);
      neg_d  = fin_res[WIDTH-1];
      ovf_d  = fin_ovf;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      func_q  <= FN_ADD;
      a_q     <= '0;
      sh_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      a_q     <= a_d;
      sh_q    <= sh_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = (state_q == ST_FIN);
  assign bus.Result     = res_q;
  assign bus.ResultHi   = hi_q;
  assign bus.isZero     = zero_q;
  assign bus.isNegative = neg_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the processor's 16-bit register-wrapped ALU. It keeps the ALUop/Func decode and the isZero/isNegative/overflow flags. It adds a start/busy/done handshake, a WIDTH parameter, iterative shifts, an iterative unsigned multiply with a high-half result, and a correct signed slt. It sits in the datapath between the A/B operand registers and the ALUout write-back, and the control FSM stalls on busy.

Parameters:
WIDTH, 16, datapath width in bits (≥4, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
A  in  WIDTH  operand A, sampled on accept
B  in  WIDTH  operand B, sampled on accept
ALUop  in  2  0=add, 1=sub, 2=use Func, 3=or
Func  in  4  operation select when ALUop=2
busy  out  1  operation in flight
done  out  1  one-cycle completion pulse
Result  out  WIDTH  low result, held until next completion
ResultHi  out  WIDTH  mul high half; 0 for all other ops
isZero  out  1  Result==0
isNegative  out  1  Result[WIDTH-1]
overflow  out  1  see arithmetic rules

Behaviour:
- Reset (async, reset_n=0): busy, done, Result, ResultHi, and all flags go to 0. The FSM goes to IDLE. An in-flight op is aborted and produces no done.
- Func codes: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 nand, 6 xor, 7 slt, 8 sll, 9 srl, 10 sra, 11 mul (unsigned), 12-15 reserved.
  - Reserved codes give Result=0 and all flags 0, with 1-cycle latency.
- FSM states: IDLE, SHIFT, MUL, FIN.
  - IDLE: start=1 latches A, B, and the decoded op.
    - Single-cycle ops go to FIN.
    - sll/srl/sra go to SHIFT with count=B[SHW-1:0]. If count=0, go directly to FIN.
    - mul goes to MUL with count=WIDTH.
  - SHIFT: shifts 1 bit per cycle and decrements count. When count reaches 0, go to FIN.
    - sra replicates the MSB.
  - MUL: shift-and-add over a 2*WIDTH accumulator, 1 multiplier bit per cycle. When count reaches 0, go to FIN.
  - FIN: registers Result, ResultHi, and flags, pulses done=1 for exactly this cycle, and returns to IDLE.
- busy=1 in every cycle after accept up to and including the cycle before FIN. busy=0 in FIN, so a start in the FIN cycle is accepted (back-to-back ops).
- Latency (start edge to done cycle):
  - single-cycle ops: 1 cycle
  - shift: max(shamt,0)+1 cycles
  - mul: WIDTH+1 cycles
- start while busy=1 is ignored; the operands and op in flight are unchanged.
- Result and flags change only in FIN or on reset.
- Arithmetic is modulo 2^WIDTH.
- overflow:
  - add: set on signed overflow (operand signs equal, result sign differs).
  - sub and slt: set on signed overflow of A-B.
  - mul: set when ResultHi≠0.
  - all other ops: 0.
- slt: Result=1 if A<B signed, else 0. The comparison is correct at every edge, including A=0x8000, B=0x7FFF, where the subtraction overflows.
  - isNegative follows Result[WIDTH-1], which is 0 for slt.
- ALUop=3 is identical to Func=3.

Decomposition:
- Package seq_alu_pkg holds:
  - the ALUop codes and Func codes as localparams/enum
  - the FSM state enum
  - a function for signed-overflow detection
- One sub-module, seq_alu_comb, is natural. It is the combinational single-cycle unit: add/sub/logic/slt producing result and overflow.
  - The shift and multiply iteration stays in seq_alu.

Test Plan:
- WIDTH=16. A=2, B=5, ALUop=0, pulse start → done 1 cycle later, Result=7, isZero=0, overflow=0. Then A=0x4000, B=0x4000 → Result=0x8000, overflow=1, isNegative=1.
- ALUop=1, A=4, B=4 → Result=0, isZero=1. Then A=0, B=8 → Result=0xFFF8, isNegative=1.
- ALUop=2, Func=7, A=0x8000, B=0x7FFF → Result=1, overflow=1. Then A=8, B=1 → Result=0.
- Func=10, A=0x8000, B=3 → busy high 3 cycles, done on cycle 4, Result=0xF000. Func=8 with B=0 → done after 1 cycle, Result=A.
- Func=11, A=0x0100, B=0x0100 → done after 17 cycles, Result=0, ResultHi=0x0001, overflow=1. A second start mid-op (A=1, B=1) is ignored. A start on the done cycle is accepted.
- Drop reset_n low during cycle 5 of a mul → all outputs 0 immediately, no done pulse. After release, a new add completes normally. Repeat the add test at WIDTH=32: 0x40000000+0x40000000 → overflow=1.
